// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters with registered sync, active-draw,
// new-frame strobe, a 6-bit frame counter and a frame-stable orientation latch.
module video_timing_gen #(
   parameter int H_ACTIVE = 1024,
   parameter int H_FP     = 24,
   parameter int H_SYNC   = 136,
   parameter int H_BP     = 160,
   parameter int V_ACTIVE = 768,
   parameter int V_FP     = 3,
   parameter int V_SYNC   = 6,
   parameter int V_BP     = 29
) (
   input  logic        clk_pixel_in,
   input  logic        rst_n_in,
   input  logic [1:0]  rotate_in,
   output logic [10:0] hcount_out,
   output logic [9:0]  vcount_out,
   output logic        hs_out,
   output logic        vs_out,
   output logic        ad_out,
   output logic        nf_out,
   output logic [5:0]  fc_out,
   output logic [1:0]  rotate_out
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // One extra bit so window ends equal to 2048/1024 still compare correctly.
   localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
   localparam logic [11:0] H_ACT_C  = 12'(H_ACTIVE);
   localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] V_ACT_C  = 11'(V_ACTIVE);
   localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [10:0] hcnt_q, hcnt_d;
   logic [9:0]  vcnt_q, vcnt_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic        ad_q, ad_d;
   logic        nf_q, nf_d;
   logic [5:0]  fc_q, fc_d;
   logic [1:0]  rot_q, rot_d;
   logic [11:0] hx;
   logic [10:0] vx;

   always_comb begin
      hcnt_d = hcnt_q + 11'd1;
      vcnt_d = vcnt_q;
      if ({1'b0, hcnt_q} == H_LAST) begin
         hcnt_d = '0;
         if ({1'b0, vcnt_q} == V_LAST) begin
            vcnt_d = '0;
         end else begin
            vcnt_d = vcnt_q + 10'd1;
         end
      end

      // Flags are decoded from the next counts so they register alongside them.
      hx   = {1'b0, hcnt_d};
      vx   = {1'b0, vcnt_d};
      hs_d = !((hx >= HS_BEG) && (hx < HS_END));
      vs_d = !((vx >= VS_BEG) && (vx < VS_END));
      ad_d = (hx < H_ACT_C) && (vx < V_ACT_C);
      nf_d = (hx == H_ACT_C) && (vx == V_ACT_C);

      fc_d  = fc_q;
      rot_d = rot_q;
      if (nf_q) begin
         fc_d  = fc_q + 6'd1;
         rot_d = rotate_in;
      end
   end

   always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         hcnt_q <= '0;
         vcnt_q <= '0;
         hs_q   <= 1'b1;
         vs_q   <= 1'b1;
         ad_q   <= 1'b1;
         nf_q   <= 1'b0;
         fc_q   <= '0;
         rot_q  <= '0;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         ad_q   <= ad_d;
         nf_q   <= nf_d;
         fc_q   <= fc_d;
         rot_q  <= rot_d;
      end
   end

   assign hcount_out = hcnt_q;
   assign vcount_out = vcnt_q;
   assign hs_out     = hs_q;
   assign vs_out     = vs_q;
   assign ad_out     = ad_q;
   assign nf_out     = nf_q;
   assign fc_out     = fc_q;
   assign rotate_out = rot_q;

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 1024, visible pixels per line.
REQ-002 Parameter H_FP, default 24, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 136, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 160, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 768, visible lines per frame.
REQ-006 Parameter V_FP, default 3, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 6, vertical sync width in lines.
REQ-008 Parameter V_BP, default 29, vertical back porch in lines.
REQ-009 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-010 clk_pixel_in  input  1  pixel clock; all state updates on its rising edge.
REQ-011 rst_n_in  input  1  asynchronous reset, active low.
REQ-012 rotate_in  input  2  requested sprite orientation; may change at any cycle.
REQ-013 hcount_out  output  11  current pixel column, 0..H_TOTAL-1.
REQ-014 vcount_out  output  10  current line, 0..V_TOTAL-1.
REQ-015 hs_out  output  1  horizontal sync, active low.
REQ-016 vs_out  output  1  vertical sync, active low.
REQ-017 ad_out  output  1  active-draw flag; high inside the visible region.
REQ-018 nf_out  output  1  new-frame strobe, one cycle wide.
REQ-019 fc_out  output  6  frame counter.
REQ-020 rotate_out  output  2  frame-stable orientation for downstream sprite renderers.

Function
REQ-021 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1344 default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (806 default).
REQ-022 hcount_out SHALL increment by 1 every clock; hcount_out = H_TOTAL-1 -> wraps to 0 on the next clock.
REQ-023 vcount_out SHALL increment only on the clock where hcount_out wraps; at hcount_out wrap with vcount_out = V_TOTAL-1, vcount_out SHALL wrap to 0 on the same edge.
REQ-024 hs_out SHALL be 0 iff H_ACTIVE+H_FP <= hcount_out < H_ACTIVE+H_FP+H_SYNC (1048..1183 default); else 1.
REQ-025 vs_out SHALL be 0 iff V_ACTIVE+V_FP <= vcount_out < V_ACTIVE+V_FP+V_SYNC (771..776 default); else 1.
REQ-026 ad_out SHALL be 1 iff hcount_out < H_ACTIVE and vcount_out < V_ACTIVE.
REQ-027 hs_out, vs_out, ad_out and nf_out SHALL correspond to the hcount_out/vcount_out values presented in the same cycle (zero relative skew).
REQ-028 nf_out SHALL be 1 for exactly one cycle per frame, when hcount_out = H_ACTIVE and vcount_out = V_ACTIVE; else 0.
REQ-029 fc_out SHALL increment by 1 (mod 64) on the clock edge that ends the nf_out=1 cycle; 63 wraps to 0.
REQ-030 rotate_out SHALL capture rotate_in on the clock edge that ends the nf_out=1 cycle and hold it for all other cycles.
REQ-031 Changes on rotate_in outside that edge SHALL NOT affect rotate_out; only the value sampled at that edge is used.
REQ-032 All outputs SHALL be glitch-free functions of registered state; no combinational path from rotate_in to any output.
REQ-033 Parameter sums SHALL fit the count widths (H_TOTAL <= 2048, V_TOTAL <= 1024); out-of-range configurations are unsupported.

Reset
REQ-034 While rst_n_in = 0 (asynchronously on its falling edge), the block SHALL force hcount_out=0, vcount_out=0, fc_out=0, rotate_out=0.
REQ-035 Consequent reset-state outputs SHALL be hs_out=1, vs_out=1, ad_out=1, nf_out=0.
REQ-036 Reset asserted mid-line or mid-frame SHALL discard the frame in progress; counting SHALL resume from (0,0) on the first rising edge after rst_n_in returns to 1.

Verification
REQ-037 Release reset, run 1344 clocks -> hcount_out steps 0..1343 then 0; vcount_out goes 0->1 on that wrap edge.
REQ-038 Run one full frame (1344x806 = 1,083,264 clocks) -> exactly 136 hs_out low cycles per line, 6x1344 vs_out low cycles per frame, 1024x768 ad_out high cycles, one nf_out pulse at (1024,768).
REQ-039 Set rotate_in=2'b10, toggle rotate_in every 7 clocks mid-frame, hold 2'b01 across the nf_out cycle -> rotate_out stays 0 until that edge, then 2'b01 for the whole next frame.
REQ-040 Run 64 frames -> fc_out counts 0..63, wraps to 0 after the 64th nf_out pulse.
REQ-041 Assert rst_n_in at (hcount 700, vcount 500) between clock edges -> outputs go to reset values immediately, without waiting for a clock; after release the counters restart at (0,0) and fc_out=0.
REQ-042 Instantiate with H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 -> H_TOTAL=12, V_TOTAL=7; sync, ad_out and nf_out windows match REQ-024..028.
